// File: rtl/bsg_fsb_trace_pkg.sv
// Shared trace-word opcodes and helpers for the FSB node trace recorder.
package bsg_fsb_trace_pkg;

   localparam int unsigned trace_op_width_lp = 4;

   // WAIT and FINISH are produced by other tools in the replay flow; the recorder never emits them.
   typedef enum logic [3:0] {
      OP_SEND   = 4'b0001,
      OP_RECV   = 4'b0010,
      OP_DONE   = 4'b0011,
      OP_WAIT   = 4'b0100,
      OP_FINISH = 4'b0101
   } trace_op_e;

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
   endfunction

endpackage

// File: rtl/bsg_fsb_trace_event_fifo.sv
// Circular event queue: up to three pushes and one pop per cycle, reports free slots.
module bsg_fsb_trace_event_fifo #(
   parameter int width_p = 69,
   parameter int els_p   = 4,
   localparam int cnt_w_lp = $clog2(els_p + 1),
   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [1:0]               push_cnt_i,
   input  logic [2:0][width_p-1:0]  push_data_i,
   input  logic                     pop_i,
   output logic [width_p-1:0]       head_o,
   output logic                     head_v_o,
   output logic [cnt_w_lp-1:0]      free_o
);

   logic [width_p-1:0]  mem_q [els_p];
   logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;
   logic [ptr_w_lp-1:0] wr_idx [3];

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         wr_idx[k] = ptr_w_lp'((int'(rd_ptr_q) + int'(count_q) + k) % els_p);
      end
      rd_ptr_d = pop_i ? ptr_w_lp'((int'(rd_ptr_q) + 1) % els_p) : rd_ptr_q;
      count_d  = count_q + cnt_w_lp'(push_cnt_i) - cnt_w_lp'(pop_i);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // The tail is unaffected by a same-cycle pop, so write slots use the old pointer and count.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < 3; k++) begin
         if (k < int'(push_cnt_i)) mem_q[wr_idx[k]] <= push_data_i[k];
      end
   end

   assign head_o   = mem_q[rd_ptr_q];
   assign head_v_o = (count_q != '0);
   assign free_o   = cnt_w_lp'(els_p) - count_q;

endmodule

// File: rtl/bsg_fsb_node_trace_recorder.sv
// Snoops the request/response handshakes and writes them as opcode-tagged words into a trace RAM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | first cycle after reset; events are queued, nothing drained
// S_CAPTURE| queue drained one word per cycle into RAM (or flushed if full)
// S_FINISH | DONE written or dropped; inputs ignored until reset
module bsg_fsb_node_trace_recorder
   import bsg_fsb_trace_pkg::*;
#(
   parameter int ring_width_p = 65,
   parameter int addr_width_p = 10,
   parameter int fifo_els_p   = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      req_v_i,
   input  logic                      req_ready_i,
   input  logic [ring_width_p-1:0]   req_data_i,
   input  logic                      resp_v_i,
   input  logic                      resp_ready_i,
   input  logic [ring_width_p-1:0]   resp_data_i,
   input  logic                      done_i,
   output logic                      mem_w_o,
   output logic [addr_width_p-1:0]   mem_addr_o,
   output logic [ring_width_p+3:0]   mem_data_o,
   output logic [addr_width_p:0]     count_o,
   output logic                      full_o,
   output logic                      overflow_o,
   output logic                      finished_o
);

   localparam int word_w_lp = ring_width_p + trace_op_width_lp;
   localparam int cnt_w_lp  = $clog2(fifo_els_p + 1);
   localparam logic [addr_width_p:0] cap_lp = {1'b1, {addr_width_p{1'b0}}};

   typedef struct packed {
      trace_op_e                op;
      logic [ring_width_p-1:0]  payload;
   } trace_word_s;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FINISH} state_e;

   state_e                      state_q, state_d;
   logic [addr_width_p:0]       count_q, count_d;
   logic                        overflow_q, overflow_d;
   logic                        done_q, done_d;

   logic [2:0]                  ev_v;
   trace_word_s                 ev_word [3];
   logic [1:0]                  n_ev, slot;
   logic [1:0]                  push_cnt;
   logic [2:0][word_w_lp-1:0]   push_data;
   logic                        done_pushed;
   logic                        pop, full, write;
   logic [word_w_lp-1:0]        head_raw;
   trace_word_s                 head;
   logic                        head_v;
   logic [cnt_w_lp-1:0]         free;

   assign full = (count_q == cap_lp);
   assign head = trace_word_s'(head_raw);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      done_d      = done_q;
      push_data   = '0;
      slot        = '0;
      done_pushed = 1'b0;

      if ((state_q != S_FINISH) && !done_q) begin
         ev_v = {done_i, resp_v_i & resp_ready_i, req_v_i & req_ready_i};
      end else begin
         ev_v = '0;
      end
      ev_word[0] = trace_word_s'{op: OP_SEND, payload: req_data_i};
      ev_word[1] = trace_word_s'{op: OP_RECV, payload: resp_data_i};
      ev_word[2] = trace_word_s'{op: OP_DONE, payload: '0};
      n_ev = popcount3(ev_v);

      // Events fill free slots in priority order; whatever is left over is lost.
      for (int k = 0; k < 3; k++) begin
         if (ev_v[k] && !full && (cnt_w_lp'(slot) < free)) begin
            push_data[slot] = ev_word[k];
            slot            = slot + 2'd1;
            if (k == 2) done_pushed = 1'b1;
         end
      end
      push_cnt = slot;

      pop   = (state_q == S_CAPTURE) && head_v;
      write = pop && !full;

      if (slot != n_ev)  overflow_d = 1'b1;
      if (pop && full)   overflow_d = 1'b1;
      if (write)         count_d    = count_q + 1'b1;
      if (done_pushed)   done_d     = 1'b1;

      case (state_q)
         S_IDLE:    state_d = S_CAPTURE;
         S_CAPTURE: begin
            if ((pop && head.op == OP_DONE) || (ev_v[2] && full)) state_d = S_FINISH;
         end
         default:   state_d = S_FINISH;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   bsg_fsb_trace_event_fifo #(
      .width_p (word_w_lp),
      .els_p   (fifo_els_p)
   ) u_fifo (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .push_cnt_i  (push_cnt),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head_raw),
      .head_v_o    (head_v),
      .free_o      (free)
   );

   assign mem_w_o    = write;
   assign mem_addr_o = count_q[addr_width_p-1:0];
   assign mem_data_o = write ? head_raw : '0;
   assign count_o    = count_q;
   assign full_o     = full;
   assign overflow_o = overflow_q;
   assign finished_o = (state_q == S_FINISH);

endmodule
